// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types and constants for the two-requester APB master arbiter
// Contents:
//   DEF_AW / DEF_DW : default APB address / data widths
//   TMO_W           : width of the ACCESS-phase watchdog counter
//   state_t         : transfer sequencer states
package apb_arb_pkg;

    localparam int DEF_AW = 40;
    localparam int DEF_DW = 32;
    localparam int TMO_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/apb_mst_arb_if.sv
// rtl/apb_mst_arb_if.sv - APB segment signals shared by the arbiter (master) and the peripherals (slave)
// Signals:
//   psel, penable, pwrite, paddr, pwdata : driven by the master
//   prdata, pready, pslverr              : driven by the addressed slave
interface apb_mst_arb_if
    import apb_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_arb_rr.sv
// rtl/apb_arb_rr.sv - two-way round-robin picker
// Ports:
//   req   in  2  pending requests
//   last  in  1  index granted most recently
//   idx   out 1  winning requester
//   valid out 1  at least one request pending
module apb_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic       idx,
    output logic       valid
);
    // With both requesting, the one not served last wins; otherwise the
    // lone requester wins (req[1] alone selects 1, req[0] alone selects 0).
    assign valid = |req;
    assign idx   = (req == 2'b11) ? ~last : req[1];
endmodule

// File: rtl/apb_mst_arb.sv
// rtl/apb_mst_arb.sv - round-robin APB master shared by two requesters, SETUP/ACCESS sequencing
// Optional ACCESS-phase watchdog: define APB_ARB_TIMEOUT_EN.
// Ports:
//   pclk, prst                  : clock, asynchronous active-high reset
//   req/addr/write/wdata 0,1    : requester transfer inputs
//   gnt/done/rdata/err 0,1      : requester ownership, completion pulse and response
//   apb (master modport)        : APB segment
module apb_mst_arb
    import apb_arb_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          pclk,
    input  logic          prst,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic          write0,
    input  logic          write1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    apb_mst_arb_if.master apb
);
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be in 1..255");
    end

    state_t        state, state_nxt;
    logic          last;
    logic          pick_idx, pick_valid;
    logic          tmo_hit;
    logic          psel_r, penable_r, pwrite_r;
    logic [AW-1:0] paddr_r;
    logic [DW-1:0] pwdata_r;

    apb_arb_rr u_rr (
        .req   ({req1, req0}),
        .last  (last),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts pready-low ACCESS cycles; expiry fires on the cycle that would
    // bring the count to TIMEOUT_CYC, unless pready rescues it.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            tmo_cnt <= '0;
        end else if (state == SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !apb.pready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == ACCESS) && !apb.pready && (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (apb.pready || tmo_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state     <= IDLE;
            last      <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= '0;
            pwdata_r  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        last     <= pick_idx;
                        gnt0     <= ~pick_idx;
                        gnt1     <= pick_idx;
                        psel_r   <= 1'b1;
                        paddr_r  <= pick_idx ? addr1  : addr0;
                        pwrite_r <= pick_idx ? write1 : write0;
                        pwdata_r <= pick_idx ? wdata1 : wdata0;
                    end
                end
                SETUP: penable_r <= 1'b1;
                ACCESS: begin
                    if (state_nxt == RESP) begin
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                        // gnt1 identifies the owner; a timeout (pready low)
                        // returns zero data with error set.
                        if (gnt1) begin
                            done1  <= 1'b1;
                            rdata1 <= (apb.pready && !pwrite_r) ? apb.prdata : '0;
                            err1   <= apb.pready ? apb.pslverr : 1'b1;
                        end else begin
                            done0  <= 1'b1;
                            rdata0 <= (apb.pready && !pwrite_r) ? apb.prdata : '0;
                            err0   <= apb.pready ? apb.pslverr : 1'b1;
                        end
                    end
                end
                RESP: begin
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                    done0  <= 1'b0;
                    done1  <= 1'b0;
                    rdata0 <= '0;
                    rdata1 <= '0;
                    err0   <= 1'b0;
                    err1   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign apb.psel    = psel_r;
    assign apb.penable = penable_r;
    assign apb.pwrite  = pwrite_r;
    assign apb.paddr   = paddr_r;
    assign apb.pwdata  = pwdata_r;
endmodule

// File: tb/tb_apb_mst_arb.sv
// tb/tb_apb_mst_arb.sv - scoreboard bench for apb_mst_arb
module tb_apb_mst_arb;
    import apb_arb_pkg::*;

    localparam int AW = 40;
    localparam int DW = 32;

    logic          pclk = 1'b0;
    logic          prst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          write0 = 1'b0, write1 = 1'b0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, done0, done1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;

    apb_mst_arb_if #(.AW(AW), .DW(DW)) apb ();

    apb_mst_arb #(.AW(AW), .DW(DW), .TIMEOUT_CYC(8)) dut (
        .pclk   (pclk),
        .prst   (prst),
        .req0   (req0),
        .req1   (req1),
        .addr0  (addr0),
        .addr1  (addr1),
        .write0 (write0),
        .write1 (write1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .err0   (err0),
        .err1   (err1),
        .apb    (apb)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int          r;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    int          slv_waits  = 0;
    logic [31:0] slv_prdata = '0;
    logic        slv_err    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int r, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge pclk);
            seen = (r == 0) ? done0 : done1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_done%0d: got no done within %0d cycles, expected a done", r, limit);
        end
    endtask

    task automatic wait_access(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge pclk);
            seen = apb.penable;
        end
        chk("reach_access", seen, 1);
    endtask

    // APB slave: inserts slv_waits pready-low cycles in each ACCESS phase
    initial begin
        int n = 0;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata  = '0;
        forever begin
            @(negedge pclk);
            apb.prdata = slv_prdata;
            if (apb.psel && apb.penable) begin
                apb.pready  = (n >= slv_waits);
                apb.pslverr = apb.pready ? slv_err : 1'b0;
                n++;
            end else begin
                apb.pready  = 1'b0;
                apb.pslverr = 1'b0;
                n = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every completion pulse
    initial begin
        int   acc_run = 0;
        exp_t e;
        forever begin
            @(negedge pclk);
            if (prst) begin
                acc_run = 0;
                continue;
            end
            if (gnt0 || gnt1) chk("gnt_exclusive", gnt0 & gnt1, 0);
            if (done0 || done1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none", done0, done1);
                end else begin
                    e = expq.pop_front();
                    chk("done_who", done1, e.r);
                    chk("done_both", done0 & done1, 0);
                    chk("access_len", acc_run, e.acc);
                    if (e.r == 0) begin
                        chk("rdata0", rdata0, e.rdata);
                        chk("err0", err0, e.err);
                        chk("idle_rdata1", rdata1, 0);
                        chk("idle_err1", err1, 0);
                    end else begin
                        chk("rdata1", rdata1, e.rdata);
                        chk("err1", err1, e.err);
                        chk("idle_rdata0", rdata0, 0);
                        chk("idle_err0", err0, 0);
                    end
                end
                acc_run = 0;
            end else if (apb.penable) begin
                acc_run++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish within time limit");
        $fatal(1, "bench timeout");
    end

    initial begin
        int last_c = 0;

        // Reset state
        repeat (2) @(negedge pclk);
        chk("rst_psel", apb.psel, 0);
        chk("rst_penable", apb.penable, 0);
        chk("rst_paddr", apb.paddr, 0);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_done", {done1, done0}, 0);
        @(posedge pclk); #1;
        prst = 1'b0;

        // Single zero-wait read from requester 0
        @(posedge pclk); #1;
        addr0 = 40'h0010015000; write0 = 1'b0;
        slv_prdata = 32'hA5A5_0001; slv_waits = 0; slv_err = 1'b0;
        expq.push_back('{0, 32'hA5A5_0001, 1'b0, 1});
        req0 = 1'b1;
        @(negedge pclk);
        chk("t1_c0_psel", apb.psel, 0);
        @(negedge pclk);
        chk("t1_c1_psel", apb.psel, 1);
        chk("t1_c1_penable", apb.penable, 0);
        chk("t1_c1_paddr", apb.paddr, 40'h0010015000);
        chk("t1_c1_gnt0", gnt0, 1);
        @(negedge pclk);
        chk("t1_c2_psel_penable", {apb.psel, apb.penable}, 2'b11);
        @(negedge pclk);
        chk("t1_c3_done0", done0, 1);
        chk("t1_c3_psel", apb.psel, 0);
        req0 = 1'b0;
        @(negedge pclk);
        chk("t1_c4_gnt0", gnt0, 0);
        chk("t1_c4_done0", done0, 0);

        // Write from requester 1, five wait states then slave error
        @(posedge pclk); #1;
        addr1 = 40'h0000300008; write1 = 1'b1; wdata1 = 32'hDEAD_BEEF;
        slv_waits = 5; slv_err = 1'b1;
        expq.push_back('{1, 32'h0, 1'b1, 6});
        req1 = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        chk("t3_gnt1", gnt1, 1);
        chk("t3_pwrite", apb.pwrite, 1);
        chk("t3_pwdata", apb.pwdata, 32'hDEAD_BEEF);
        chk("t3_paddr", apb.paddr, 40'h0000300008);
        wait_done(1, 20);
        req1 = 1'b0;

        // Contention: both held for four transfers, expect 0,1,0,1
        @(posedge pclk); #1;
        slv_waits = 0; slv_err = 1'b0; slv_prdata = 32'h1234_5678;
        addr0 = 40'h20; write0 = 1'b0;
        addr1 = 40'h24; write1 = 1'b1; wdata1 = 32'hCAFE_0001;
        expq.push_back('{0, 32'h1234_5678, 1'b0, 1});
        expq.push_back('{1, 32'h0, 1'b0, 1});
        expq.push_back('{0, 32'h1234_5678, 1'b0, 1});
        expq.push_back('{1, 32'h0, 1'b0, 1});
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_done(k % 2, 10);
            if (k > 0) chk("contention_spacing", cyc - last_c, 4);
            last_c = cyc;
        end
        req0 = 1'b0; req1 = 1'b0;

        // Stuck slave
        @(posedge pclk); #1;
        slv_waits = 1_000_000;
        addr0 = 40'h40; write0 = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        expq.push_back('{0, 32'h0, 1'b1, 8});
        req0 = 1'b1;
        wait_done(0, 20);
        req0 = 1'b0;
        @(posedge pclk); #1;
        req0 = 1'b1;
        wait_access(10);
`else
        req0 = 1'b1;
        repeat (1000) @(negedge pclk);
        chk("no_tmo_access", {apb.psel, apb.penable}, 2'b11);
        chk("no_tmo_done0", done0, 0);
        wait_access(2);
`endif

        // Reset in the middle of ACCESS
        @(posedge pclk); #1;
        prst = 1'b1;
        #1;
        chk("rst_mid_psel", apb.psel, 0);
        chk("rst_mid_penable", apb.penable, 0);
        chk("rst_mid_gnt0", gnt0, 0);
        chk("rst_mid_done0", done0, 0);
        chk("rst_mid_paddr", apb.paddr, 0);
        req0 = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        prst = 1'b0;

        // First dual request after reset must go to requester 0
        slv_waits = 0; slv_prdata = 32'h0BAD_F00D;
        addr0 = 40'h50; write0 = 1'b0;
        addr1 = 40'h54; write1 = 1'b0;
        expq.push_back('{0, 32'h0BAD_F00D, 1'b0, 1});
        expq.push_back('{1, 32'h0BAD_F00D, 1'b0, 1});
        req0 = 1'b1; req1 = 1'b1;
        wait_done(0, 10);
        req0 = 1'b0;
        wait_done(1, 10);
        req1 = 1'b0;

        repeat (3) @(negedge pclk);
        chk("queue_empty", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
